// File: rtl/class_pkg.sv
// Shared definitions for the class router: default parameter set,
// class-count and log2 helpers, and class-field extraction.
package class_pkg;

  localparam int DEF_DATA_SIZE  = 10;
  localparam int DEF_CLASS_BITS = 1;
  localparam int DEF_MAIN_SIZE  = 8;
  localparam int DEF_AF_LEVEL   = DEF_MAIN_SIZE - 2;
  localparam int DEF_AE_LEVEL   = 1;
  localparam int DEF_CNT_SIZE   = 8;

  // Widest word the extraction helper accepts.
  localparam int MAX_DATA_SIZE  = 64;

  function automatic int num_classes(input int class_bits);
    return 1 << class_bits;
  endfunction

  // Ceiling log2, usable in constant expressions.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Class field sits in the MSBs of the word.
  function automatic logic [31:0] class_of(input logic [MAX_DATA_SIZE-1:0] word,
                                           input int data_size,
                                           input int class_bits);
    logic [MAX_DATA_SIZE-1:0] shifted;
    logic [MAX_DATA_SIZE-1:0] mask;
    shifted = word >> (data_size - class_bits);
    mask    = (64'd1 << class_bits) - 64'd1;
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/class_fifo.sv
// Per-class synchronous FIFO with registered read port, occupancy flags
// and a saturating overflow drop counter.
module class_fifo
  import class_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int MAIN_SIZE = DEF_MAIN_SIZE,
  parameter int AF_LEVEL  = MAIN_SIZE - 2,
  parameter int AE_LEVEL  = DEF_AE_LEVEL,
  parameter int CNT_SIZE  = DEF_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 dout_valid,
  output logic                 af,
  output logic                 ae,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_SIZE-1:0]  drop_cnt
);

  localparam int PTR_W = log2_ceil(MAIN_SIZE);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_SIZE-1:0] mem [MAIN_SIZE];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [CNT_SIZE-1:0]  drop_q, drop_d;
  logic                 do_push, do_pop;

  assign full  = (occ_q == OCC_W'(MAIN_SIZE));
  assign empty = (occ_q == '0);
  assign af    = (occ_q >= OCC_W'(AF_LEVEL));
  assign ae    = (occ_q <= OCC_W'(AE_LEVEL));

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign drop_cnt   = drop_q;

  // Next-state: a pop on empty is ignored (no fall-through); a push on full
  // only lands if the same cycle frees a slot, otherwise it is counted.
  always_comb begin
    do_pop       = pop && !empty;
    do_push      = push && (!full || do_pop);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    dout_d       = dout_q;
    dout_valid_d = do_pop;
    drop_d       = drop_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dout_d   = mem[rd_ptr_q];
    end
    if (do_push && !do_pop)      occ_d = occ_q + OCC_W'(1);
    else if (!do_push && do_pop) occ_d = occ_q - OCC_W'(1);

    if (push && !do_push && (drop_q != '1)) drop_d = drop_q + CNT_SIZE'(1);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      drop_q       <= drop_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/class_router.sv
// Steers incoming words by their class field into per-class FIFOs and
// aggregates their almost-full flags into an upstream pause.
module class_router
  import class_pkg::*;
#(
  parameter int  DATA_SIZE   = DEF_DATA_SIZE,
  parameter int  CLASS_BITS  = DEF_CLASS_BITS,
  parameter int  MAIN_SIZE   = DEF_MAIN_SIZE,
  parameter int  AF_LEVEL    = MAIN_SIZE - 2,
  parameter int  AE_LEVEL    = DEF_AE_LEVEL,
  parameter int  CNT_SIZE    = DEF_CNT_SIZE,
  localparam int NUM_CLASSES = num_classes(CLASS_BITS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_SIZE-1:0]            in,
  input  logic                            valid_in,
  input  logic [NUM_CLASSES-1:0]          pop,
  output logic [NUM_CLASSES*DATA_SIZE-1:0] out,
  output logic [NUM_CLASSES-1:0]          valid_out,
  output logic [NUM_CLASSES-1:0]          AF,
  output logic [NUM_CLASSES-1:0]          AE,
  output logic [NUM_CLASSES-1:0]          full,
  output logic [NUM_CLASSES-1:0]          empty,
  output logic                            pause,
  output logic [NUM_CLASSES*CNT_SIZE-1:0] drop_cnt
);

  logic [CLASS_BITS-1:0]  cls;
  logic [NUM_CLASSES-1:0] push_en;

  assign cls   = CLASS_BITS'(class_of(MAX_DATA_SIZE'(in), DATA_SIZE, CLASS_BITS));
  assign pause = |AF;

  // One-hot push enable for the addressed class.
  always_comb begin
    push_en = '0;
    if (valid_in) push_en[cls] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
    class_fifo #(
      .DATA_SIZE (DATA_SIZE),
      .MAIN_SIZE (MAIN_SIZE),
      .AF_LEVEL  (AF_LEVEL),
      .AE_LEVEL  (AE_LEVEL),
      .CNT_SIZE  (CNT_SIZE)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_en[k]),
      .pop        (pop[k]),
      .din        (in),
      .dout       (out[k*DATA_SIZE +: DATA_SIZE]),
      .dout_valid (valid_out[k]),
      .af         (AF[k]),
      .ae         (AE[k]),
      .full       (full[k]),
      .empty      (empty[k]),
      .drop_cnt   (drop_cnt[k*CNT_SIZE +: CNT_SIZE])
    );
  end

endmodule

// File: tb/tb_class_router.sv
// Scoreboard bench for class_router: default instance under directed and
// random traffic against a queue model, plus a 4-class depth-4 instance for
// mid-operation reset and slice steering.
module tb_class_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // ---------------- default instance ----------------
  logic        rst1;
  logic [9:0]  in1;
  logic        valid1;
  logic [1:0]  pop1;
  logic [19:0] out1;
  logic [1:0]  vout1, af1, ae1, full1, empty1;
  logic        pause1;
  logic [15:0] drop1;

  class_router dut1 (
    .clk(clk), .reset(rst1), .in(in1), .valid_in(valid1), .pop(pop1),
    .out(out1), .valid_out(vout1), .AF(af1), .AE(ae1), .full(full1),
    .empty(empty1), .pause(pause1), .drop_cnt(drop1)
  );

  // ---------------- scaled instance ----------------
  logic        rst2;
  logic [9:0]  in2;
  logic        valid2;
  logic [3:0]  pop2;
  logic [39:0] out2;
  logic [3:0]  vout2, af2, ae2, full2, empty2;
  logic        pause2;
  logic [31:0] drop2;

  class_router #(.CLASS_BITS(2), .MAIN_SIZE(4), .AF_LEVEL(2)) dut2 (
    .clk(clk), .reset(rst2), .in(in2), .valid_in(valid2), .pop(pop2),
    .out(out2), .valid_out(vout2), .AF(af2), .AE(ae2), .full(full2),
    .empty(empty2), .pause(pause2), .drop_cnt(drop2)
  );

  // ---------------- reference model (default instance) ----------------
  localparam int DEPTH = 8;
  logic [9:0] mq    [2][$];  // words held per class
  logic [9:0] exp_q [2][$];  // words expected on out, in order
  int         dm    [2];     // drop counts

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    logic [1:0]  e_empty, e_full, e_af, e_ae;
    logic [15:0] e_drop;
    for (int k = 0; k < 2; k++) begin
      e_empty[k] = (mq[k].size() == 0);
      e_full[k]  = (mq[k].size() == DEPTH);
      e_af[k]    = (mq[k].size() >= DEPTH - 2);
      e_ae[k]    = (mq[k].size() <= 1);
      e_drop[k*8 +: 8] = 8'(dm[k]);
    end
    chk("empty", 64'(empty1), 64'(e_empty));
    chk("full",  64'(full1),  64'(e_full));
    chk("AF",    64'(af1),    64'(e_af));
    chk("AE",    64'(ae1),    64'(e_ae));
    chk("pause", 64'(pause1), 64'(|e_af));
    chk("drop_cnt", 64'(drop1), 64'(e_drop));
    for (int k = 0; k < 2; k++)
      chk("missing_valid_out", 64'(exp_q[k].size()), 64'd0);
  endtask

  // One cycle of stimulus; the model applies pops first so a full FIFO with
  // a same-cycle pop accepts the push, and an empty FIFO ignores the pop.
  task automatic step(input logic v, input logic [9:0] d, input logic [1:0] p);
    int c;
    @(negedge clk);
    valid1 = v; in1 = d; pop1 = p;
    for (int k = 0; k < 2; k++)
      if (p[k] && mq[k].size() > 0) exp_q[k].push_back(mq[k].pop_front());
    if (v) begin
      c = int'(d[9]);
      if (mq[c].size() < DEPTH) mq[c].push_back(d);
      else if (dm[c] < 255) dm[c]++;
    end
    @(posedge clk);
    #2;
    check_flags();
  endtask

  task automatic drain(input int k);
    logic [1:0] p;
    p = 2'b00;
    p[k] = 1'b1;
    while (mq[k].size() > 0) step(1'b0, 10'h0, p);
    step(1'b0, 10'h0, 2'b00);
  endtask

  // Monitor: pops the scoreboard whenever a valid_out appears, otherwise
  // requires the out slice to hold its last value.
  logic [9:0] last_out [2];
  initial begin
    last_out[0] = '0;
    last_out[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst1) begin
        last_out[0] = '0;
        last_out[1] = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (vout1[k]) begin
            if (exp_q[k].size() == 0) begin
              chk("spurious_valid_out", 64'(vout1[k]), 64'd0);
            end else begin
              logic [9:0] e;
              e = exp_q[k].pop_front();
              chk("out_data", 64'(out1[k*10 +: 10]), 64'(e));
              last_out[k] = e;
            end
          end else begin
            chk("out_hold", 64'(out1[k*10 +: 10]), 64'(last_out[k]));
          end
        end
      end
    end
  end

  initial begin
    dm[0] = 0; dm[1] = 0;
    rst1 = 1'b0; valid1 = 1'b1; in1 = 10'h3FF; pop1 = 2'b00;
    rst2 = 1'b0; valid2 = 1'b0; in2 = 10'h0;   pop2 = 4'h0;

    // Reset held with a push request present: nothing may be stored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 64'(empty1), 64'h3);
    chk("rst_AE",    64'(ae1),    64'h3);
    chk("rst_full",  64'(full1),  64'h0);
    chk("rst_AF",    64'(af1),    64'h0);
    chk("rst_pause", 64'(pause1), 64'h0);
    chk("rst_drop",  64'(drop1),  64'h0);
    chk("rst_vout",  64'(vout1),  64'h0);
    chk("rst_out",   64'(out1),   64'h0);
    valid1 = 1'b0;
    rst1 = 1'b1;
    rst2 = 1'b1;

    // Steering.
    step(1'b1, 10'h0FF, 2'b00);
    step(1'b1, 10'h2AA, 2'b00);
    step(1'b1, 10'h001, 2'b00);
    step(1'b0, 10'h000, 2'b11);
    step(1'b0, 10'h000, 2'b01);
    step(1'b0, 10'h000, 2'b00);

    // Fill class 1 to AF, then full, then overflow by one.
    for (int i = 0; i < 6; i++) step(1'b1, 10'h200 | 10'(i * 7), 2'b00);
    chk("pause_after_6", 64'(pause1), 64'h1);
    for (int i = 6; i < 9; i++) step(1'b1, 10'h200 | 10'(i * 7), 2'b00);
    chk("drop1_after_9", 64'(drop1[15:8]), 64'h1);
    drain(1);

    // Class 0 full, same-cycle push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, 10'(i + 16), 2'b00);
    step(1'b1, 10'h0AB, 2'b01);
    chk("full_stays", 64'(full1[0]), 64'h1);
    drain(0);

    // Pops on empty, then push+pop on empty.
    step(1'b0, 10'h000, 2'b11);
    step(1'b0, 10'h000, 2'b11);
    step(1'b1, 10'h055, 2'b01);
    chk("empty_pushpop_vout", 64'(vout1), 64'h0);
    drain(0);

    // Drive class 1 drop counter into saturation.
    for (int i = 0; i < 8; i++) step(1'b1, 10'h300 | 10'(i), 2'b00);
    for (int i = 0; i < 260; i++) step(1'b1, 10'h3FF, 2'b00);
    chk("drop_saturated", 64'(drop1[15:8]), 64'hFF);
    drain(1);

    // Random traffic: light popping first (overflow pressure), then heavy.
    for (int i = 0; i < 3000; i++) begin
      logic       v;
      logic [9:0] d;
      logic [1:0] p;
      v = ($urandom_range(0, 3) != 0);
      d = 10'($urandom);
      if (i < 1500) p = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      else          p = 2'($urandom);
      step(v, d, p);
    end
    drain(0);
    drain(1);

    // Scaled instance: partial fill, asynchronous mid-operation reset.
    @(negedge clk);
    valid2 = 1'b1; in2 = 10'h011;
    @(negedge clk); in2 = 10'h122;
    @(negedge clk); in2 = 10'h233;
    @(negedge clk); in2 = 10'h344;
    @(negedge clk); in2 = 10'h2BB;
    @(negedge clk); valid2 = 1'b0;
    chk("s_filled_empty", 64'(empty2), 64'h0);
    chk("s_filled_AF",    64'(af2),    64'h4);
    chk("s_filled_pause", 64'(pause2), 64'h1);
    rst2 = 1'b0;
    #1;
    chk("s_rst_empty", 64'(empty2), 64'hF);
    chk("s_rst_AE",    64'(ae2),    64'hF);
    chk("s_rst_full",  64'(full2),  64'h0);
    chk("s_rst_pause", 64'(pause2), 64'h0);
    chk("s_rst_drop",  64'(drop2),  64'h0);
    chk("s_rst_out",   64'(out2),   64'h0);
    @(negedge clk);
    rst2 = 1'b1;
    valid2 = 1'b1; in2 = 10'h3C5;
    @(negedge clk);
    valid2 = 1'b0; pop2 = 4'hF;
    @(posedge clk);
    #1;
    chk("s_vout",  64'(vout2), 64'h8);
    chk("s_out",   64'(out2),  {24'h0, 10'h3C5, 30'h0});
    @(negedge clk);
    pop2 = 4'h0;
    @(posedge clk);
    #1;
    chk("s_vout_after", 64'(vout2), 64'h0);
    chk("s_empty_after", 64'(empty2), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/class_router.md
# class_router

Parametrised successor to the two-class splitter. Incoming words are steered by a class field in their MSBs into one of 2**CLASS_BITS internal FIFOs, each drained independently by a downstream pop. The block raises per-class almost-full/almost-empty flags and an aggregate pause toward the upstream source, and counts words dropped on overflow. It sits between the PCIe ingress datapath and the per-class arbiters of the adaptive switch.

## Interface
- DATA_SIZE, 10, word width including the class field
- CLASS_BITS, 1, class field width; NUM_CLASSES = 2**CLASS_BITS
- MAIN_SIZE, 8, FIFO depth in words, power of two, at least 4
- AF_LEVEL, MAIN_SIZE-2, occupancy at or above which AF is set
- AE_LEVEL, 1, occupancy at or below which AE is set
- CNT_SIZE, 8, width of each drop counter

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in  in  DATA_SIZE  input word; class = in[DATA_SIZE-1 -: CLASS_BITS]
- valid_in  in  1  in is valid this cycle
- pop  in  NUM_CLASSES  per-class read request
- out  out  NUM_CLASSES*DATA_SIZE  per-class registered read data, class k at [k*DATA_SIZE +: DATA_SIZE]
- valid_out  out  NUM_CLASSES  out slice k holds a word popped last cycle
- AF  out  NUM_CLASSES  per-class almost full
- AE  out  NUM_CLASSES  per-class almost empty
- full, empty  out  NUM_CLASSES each  per-class exact status
- pause  out  1  OR of AF, upstream must stop sending
- drop_cnt  out  NUM_CLASSES*CNT_SIZE  per-class overflow drop counters

## Operation
- Push: when valid_in=1, the word (class field included, unmodified) is written to FIFO[class].
- Push to a full FIFO without a same-cycle pop to that class: word discarded, drop_cnt[class] increments, saturating at all-ones.
- Push and pop to the same full FIFO in one cycle: both take effect, occupancy unchanged, no drop.
- Pop on an empty FIFO is ignored: valid_out=0, out slice holds its previous value.
- Simultaneous push and pop on an empty FIFO: the pop is ignored, the push is stored, and there is no fall-through.
- Pointers are log2(MAIN_SIZE) bits and wrap naturally. The occupancy counter is log2(MAIN_SIZE)+1 bits, range 0..MAIN_SIZE.
- Flags are derived combinationally from the registered occupancy: AF = occ>=AF_LEVEL, AE = occ<=AE_LEVEL, full = occ==MAIN_SIZE, empty = occ==0.
- Classes are fully independent. Activity on one class never alters the state of another.

## Timing
- Reset (reset=0, asynchronous):
  - All occupancies, pointers, out, valid_out and drop_cnt are 0.
  - Consequently empty=all ones, AE=all ones, full=0, AF=0, pause=0.
  - Storage contents are don't-care.
- Reset asserted mid-operation clears everything immediately. Words still in the FIFOs are lost and not counted as drops.
- Write latency: a word pushed at edge n is poppable at edge n+1, and its flags update after edge n.
- Read latency: pop at edge n gives out/valid_out valid after edge n, for one cycle per pop. Back-to-back pops stream one word per cycle.
- pause follows AF combinationally. Upstream tolerates up to MAIN_SIZE-AF_LEVEL words in flight before overflow.

## Structure
- Shared package class_pkg: NUM_CLASSES and log2 helper function, a default parameter set, and the class-field extraction function.
- One sub-module, class_fifo, instantiated NUM_CLASSES times by generate:
  - synchronous FIFO with push, pop, data in/out, occupancy, flags and a saturating drop counter;
  - parameters DATA_SIZE, MAIN_SIZE, AF_LEVEL, AE_LEVEL, CNT_SIZE.
- The top level holds only the class decode, the per-class push enables, the output flattening and the pause OR.

## Test plan
- Reset: drive reset=0 for 3 cycles with valid_in=1 and in=10'h3FF. Expect no push, empty=2'b11, AE=2'b11, pause=0, drop_cnt=0.
- Steering (defaults):
  - push 10'h0FF, then 10'h2AA, then 10'h001;
  - then pop class 0 twice and class 1 once;
  - expect out0=10'h0FF then 10'h001, out1=10'h2AA, each with valid_out for one cycle.
- Fill and pause:
  - push 6 words of class 1 with no pops: AF[1]=1 and pause=1 after the 6th edge;
  - push 2 more: full[1]=1;
  - push a 9th: drop_cnt[1]=1, and FIFO contents are unchanged when drained.
- Full with pop: with class 0 full, push and pop class 0 in the same cycle. Expect occupancy to stay 8, drop_cnt[0]=0, and the oldest word on out0.
- Empty pop: pop class 0 and class 1 on empty FIFOs. Expect valid_out=0 and out unchanged. Same-cycle push and pop on empty stores the word with valid_out=0.
- Mid-operation reset and scaling:
  - with CLASS_BITS=2 and MAIN_SIZE=4, fill classes 0-3 partially and assert reset for 1 cycle;
  - expect all empty and AE=4'hF;
  - then a single push to class 3 (in[9:8]=2'b11) appears only on the out slice for class 3.
